// File: rtl/ram_cmd_ctrl.sv
// Purpose: command-driven single-port RAM controller; opcodes load write/read pointers, write or read.
// Latency: read data valid on the clock edge after the read command is accepted.
// Backpressure: rx_ready drops while read data is held unconsumed (tx_valid && !tx_ready).
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (control state only, memory kept)
//   rx_valid/rx_ready  command handshake; din = {opcode[1:0], payload[WORD_SIZE-1:0]}
//   tx_valid/tx_ready  read-data handshake; dout is registered read data
//   addr_err           sticky flag, set by any access to an address >= MEM_DEPTH
//
// Optional feature macro: RAM_AUTO_INC_EN -- post-increments the write pointer after each
// write and the read pointer after each read, wrapping MEM_DEPTH-1 (or any out-of-range
// value) back to 0. Without it, pointers change only through the load opcodes.
module ram_cmd_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int WORD_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   input  logic [WORD_SIZE+1:0] din,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [WORD_SIZE-1:0] dout,
   output logic                 addr_err
);

   typedef enum logic {IDLE, TX_WAIT} state_t;

   localparam logic [1:0] OP_WADDR = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_RADDR = 2'b10;
   localparam logic [1:0] OP_READ  = 2'b11;

   // One extra bit so MEM_DEPTH == 2**ADDR_SIZE is representable.
   localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);

   state_t                 state, state_nxt;
   logic [ADDR_SIZE-1:0]   wr_addr, rd_addr;
   logic [WORD_SIZE-1:0]   mem [0:MEM_DEPTH-1];
   logic [1:0]             op;
   logic [WORD_SIZE-1:0]   payload;
   logic                   accept, rd_acc, wr_ok, rd_ok, do_write;

   assign op       = din[WORD_SIZE+1:WORD_SIZE];
   assign payload  = din[WORD_SIZE-1:0];
   assign tx_valid = (state == TX_WAIT);
   assign rx_ready = !(tx_valid && !tx_ready);
   assign accept   = rx_valid && rx_ready;
   assign rd_acc   = accept && (op == OP_READ);
   assign wr_ok    = {1'b0, wr_addr} < DEPTH;
   assign rd_ok    = {1'b0, rd_addr} < DEPTH;
   // rst_n gate: a command offered during reset must never reach the array.
   assign do_write = rst_n && accept && (op == OP_WRITE) && wr_ok;

`ifdef RAM_AUTO_INC_EN
   localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

   // Anything at or beyond the last word wraps to 0, so a stray pointer recovers.
   function automatic logic [ADDR_SIZE-1:0] bump(input logic [ADDR_SIZE-1:0] a);
      return (a >= LAST) ? '0 : a + 1'b1;
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // In TX_WAIT without tx_ready, rx_ready is low so no read can be accepted and we hold.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rd_acc) state_nxt = TX_WAIT;
         TX_WAIT: if (tx_ready && !rd_acc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout     <= '0;
         wr_addr  <= '0;
         rd_addr  <= '0;
         addr_err <= 1'b0;
      end else if (accept) begin
         case (op)
            OP_WADDR: wr_addr <= payload[ADDR_SIZE-1:0];
            OP_WRITE: begin
               if (!wr_ok) addr_err <= 1'b1;
`ifdef RAM_AUTO_INC_EN
               wr_addr <= bump(wr_addr);
`endif
            end
            OP_RADDR: rd_addr <= payload[ADDR_SIZE-1:0];
            OP_READ: begin
               dout <= rd_ok ? mem[rd_addr] : '0;
               if (!rd_ok) addr_err <= 1'b1;
`ifdef RAM_AUTO_INC_EN
               rd_addr <= bump(rd_addr);
`endif
            end
            default: ;
         endcase
      end
   end

   // Storage has no reset so its contents survive a controller reset.
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_addr] <= payload;
   end

endmodule
